alu_seq_ctrl: RTL and testbench
===============================

// Module: alu_seq_ctrl
// PURPOSE
//  Multi-byte arithmetic/logic sequencer driving one external alu8b (dual-74181) slice.
//  Runs the slice serially, LSB byte first, one byte per clock, chaining the active-low carry.
//  Sits between the control unit (start/done handshake) and the alu8b instance; owns its A/B/S/M/cin.
// PARAMETERS
//  NBYTES  4  operand width in bytes (>=1); W = 8*NBYTES
// PORTS
//  clk       in   1   clock
//  reset     in   1   synchronous, active-high reset
//  start     in   1   request; accepted only when busy=0
//  op        in   3   operation (see BEHAVIOUR)
//  a, b      in   W   operands, sampled on accept
//  cin       in   1   active-high carry in, used by ADC only
//  busy      out  1   high from the cycle after accept through the done cycle
//  done      out  1   one-cycle pulse: result/flags valid
//  err       out  1   unsupported op; valid with done
//  result    out  W   result register, held until next non-CMP completion
//  carry     out  1   active-high carry out (SUB/CMP: 1 = no borrow); 0 for logic ops
//  zero      out  1   all W bits of the ALU output were 0
//  alu_a/alu_b out 8  byte operands to the slice
//  alu_s     out  4   74181 S select;  alu_m out 1: 74181 M
//  alu_cin   out  1   slice CNb (active-low carry in)
//  alu_f     in   8   slice F;  alu_cout in 1: slice CN4b (active-low)
// BEHAVIOUR
//  Reset: busy=0 done=0 err=0 result=0 carry=0 zero=0 alu_a=alu_b=0 alu_s=0 alu_m=1 alu_cin=1; FSM->IDLE.
//  FSM IDLE -> RUN -> DONE -> IDLE. start accepted at edge k (IDLE): latch a, b, op, cin; idx=0.
//  RUN: cycles k+1..k+NBYTES; byte idx drives alu_a=a[8*idx+:8], alu_b=b[8*idx+:8].
//   Byte 0 alu_cin: ADD 1, ADC ~cin, SUB/CMP 0. Byte i>0: alu_cin = alu_cout captured from byte i-1.
//   Each edge: res byte idx <= alu_f; zacc &= (alu_f==0); cacc <= alu_cout; idx++.
//   Advance to DONE after idx==NBYTES-1.
//  DONE: cycle k+NBYTES+1, done=1; result updated (not for CMP); carry=~cacc; zero=zacc; -> IDLE.
//  Ops (op): 000 ADD S=1001 M=0 | 001 ADC S=1001 M=0 | 010 SUB S=0110 M=0 | 011 CMP as SUB, result kept.
//  op[2]=1: logic ops (see CONFIGURATION); never cascades carry.
//  start while busy: ignored (no queueing). Outside RUN, alu_* held at reset values.
//  Reset in any state: abort to IDLE next edge, no done pulse, outputs to reset values.
//  NBYTES=1: RUN lasts exactly one cycle; done at k+2.
//  Error path: IDLE -> DONE directly; done=err=1 at k+1; result/carry/zero unchanged.
//  err clears on the next accepted start. Slice AEB output is not used.
// CONFIGURATION
//  ALU_SEQ_LOGIC_EN defined: op 100 AND S=1011 | 101 OR S=1110 | 110 XOR S=0110 | 111 NOT-A S=0000;
//   all M=1, alu_cin=1, run NBYTES cycles like arithmetic, carry=0, zero from alu_f, err=0.
//  ALU_SEQ_LOGIC_EN undefined: any op[2]=1 takes the error path; no ALU cycles issued.
// TESTING (NBYTES=4, real alu8b attached)
//  ADD 0x00FFFFFF+0x00000001 -> result 0x01000000, carry 0, zero 0, done exactly at k+5.
//  ADD 0xFFFFFFFF+0x00000001 -> result 0, carry 1, zero 1; busy high k+1..k+5.
//  SUB 0x10-0x20 -> 0xFFFFFFF0, carry 0; then CMP 5,5 -> result still 0xFFFFFFF0, zero 1, carry 1.
//  ADC cin=1, 1+1 -> 3; start pulsed again at k+2 is ignored (single done pulse).
//  reset asserted at k+3 of an ADD -> IDLE at k+4, no done, busy=0, result=0, alu_cin=1.
//  XOR 0xF0F0F0F0^0xFFFF0000 -> 0x0F0FF0F0 with macro; without macro op=110 -> done=err=1 at k+1.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: byte-serial multi-byte ALU sequencer driving one external alu8b slice, LSB byte first.
// Define ALU_SEQ_LOGIC_EN to enable logic ops (op[2]=1); otherwise they take the error path.
module alu_seq_ctrl #(
  parameter int NBYTES = 4,
  localparam int W = 8 * NBYTES
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         zero,
  output logic [7:0]   alu_a,
  output logic [7:0]   alu_b,
  output logic [3:0]   alu_s,
  output logic         alu_m,
  output logic         alu_cin,
  input  logic [7:0]   alu_f,
  input  logic         alu_cout
);
`ifdef ALU_SEQ_LOGIC_EN
  localparam bit LOGIC_EN = 1'b1;
`else
  localparam bit LOGIC_EN = 1'b0;
`endif
  localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   sh_a_q, sh_a_d, sh_b_q, sh_b_d, res_q, res_d, result_q, result_d;
  logic           zacc_q, zacc_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic           carry_q, carry_d, zero_q, zero_d, alu_m_q, alu_m_d, alu_cin_q, alu_cin_d;
  logic [7:0]     alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]     alu_s_q, alu_s_d, sel_s;
  logic           bad_op;
  assign sel_s = op[2] ? (op[1:0] == 2'd0 ? 4'b1011 : op[1:0] == 2'd1 ? 4'b1110 :
                          op[1:0] == 2'd2 ? 4'b0110 : 4'b0000)
                       : (op[1] ? 4'b0110 : 4'b1001);
  assign bad_op = op[2] & ~LOGIC_EN;
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    op_d      = op_q;
    sh_a_d    = sh_a_q;
    sh_b_d    = sh_b_q;
    res_d     = res_q;
    result_d  = result_q;
    zacc_d    = zacc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_s_d   = alu_s_q;
    alu_m_d   = alu_m_q;
    alu_cin_d = alu_cin_q;
    if (state_q == IDLE && start) begin
      op_d   = op;
      busy_d = 1'b1;
      err_d  = bad_op;
      if (bad_op) begin
        state_d = DONE;
        done_d  = 1'b1;
      end else begin
        state_d   = RUN;
        idx_d     = '0;
        sh_a_d    = a >> 8;
        sh_b_d    = b >> 8;
        res_d     = '0;
        zacc_d    = 1'b1;
        alu_a_d   = a[7:0];
        alu_b_d   = b[7:0];
        alu_s_d   = sel_s;
        alu_m_d   = op[2];
        alu_cin_d = op[2] ? 1'b1 : op[1] ? 1'b0 : op[0] ? ~cin : 1'b1;
      end
    end else if (state_q == RUN) begin
      // Result bytes enter at the top and shift down, so byte 0 lands at the bottom after NBYTES steps.
      res_d     = (W'(alu_f) << (W - 8)) | (res_q >> 8);
      zacc_d    = zacc_q & ~|alu_f;
      idx_d     = idx_q + IW'(1);
      sh_a_d    = sh_a_q >> 8;
      sh_b_d    = sh_b_q >> 8;
      alu_a_d   = sh_a_q[7:0];
      alu_b_d   = sh_b_q[7:0];
      alu_cin_d = alu_m_q | alu_cout;
      if (idx_q == IW'(NBYTES - 1)) begin
        state_d   = DONE;
        done_d    = 1'b1;
        result_d  = op_q == 3'b011 ? result_q : res_d;
        carry_d   = ~op_q[2] & ~alu_cout;
        zero_d    = zacc_d;
        alu_a_d   = '0;
        alu_b_d   = '0;
        alu_s_d   = '0;
        alu_m_d   = 1'b1;
        alu_cin_d = 1'b1;
      end
    end else if (state_q == DONE) begin
      state_d = IDLE;
      busy_d  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      op_q      <= '0;
      sh_a_q    <= '0;
      sh_b_q    <= '0;
      res_q     <= '0;
      result_q  <= '0;
      zacc_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_s_q   <= '0;
      alu_m_q   <= 1'b1;
      alu_cin_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      op_q      <= op_d;
      sh_a_q    <= sh_a_d;
      sh_b_q    <= sh_b_d;
      res_q     <= res_d;
      result_q  <= result_d;
      zacc_q    <= zacc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_s_q   <= alu_s_d;
      alu_m_q   <= alu_m_d;
      alu_cin_q <= alu_cin_d;
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign result  = result_q;
  assign carry   = carry_q;
  assign zero    = zero_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_s   = alu_s_q;
  assign alu_m   = alu_m_q;
  assign alu_cin = alu_cin_q;
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: scoreboard bench for alu_seq_ctrl with a behavioural 74181-pair slice attached.
module tb_alu_seq_ctrl;
  localparam int NB = 4;
  localparam int W = 8 * NB;
`ifdef ALU_SEQ_LOGIC_EN
  localparam bit LOGIC_EN = 1'b1;
`else
  localparam bit LOGIC_EN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, cin = 1'b0;
  logic [2:0] op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic busy, done, err, carry, zero, alu_m, alu_cin, alu_cout;
  logic [W-1:0] result;
  logic [7:0] alu_a, alu_b, alu_f;
  logic [3:0] alu_s;
  int checks = 0, fails = 0, cyc = 0;
  typedef struct {logic [W-1:0] res; logic c; logic z; logic e; int cyc;} exp_t;
  exp_t q[$];
  logic [W-1:0] m_res = '0;
  logic m_c = 1'b0, m_z = 1'b0;
  logic prev_done = 1'b0;
  alu_seq_ctrl #(.NBYTES(NB)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .err(err), .result(result), .carry(carry), .zero(zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Slice stand-in: active-high data, active-low carry in/out, only the S/M codes the sequencer issues.
  always_comb begin
    logic [8:0] s9;
    s9 = 9'd0;
    alu_f = 8'h00;
    alu_cout = 1'b1;
    if (alu_m) begin
      alu_f = alu_s == 4'b1011 ? (alu_a & alu_b) : alu_s == 4'b1110 ? (alu_a | alu_b) :
              alu_s == 4'b0110 ? (alu_a ^ alu_b) : alu_s == 4'b0000 ? ~alu_a : 8'h00;
    end else begin
      s9 = {1'b0, alu_a} + {1'b0, (alu_s == 4'b0110 ? ~alu_b : alu_b)} + {8'd0, ~alu_cin};
      alu_f = s9[7:0];
      alu_cout = ~s9[8];
    end
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  // Reference model: whole-word arithmetic on the operands, independent of byte sequencing.
  task automatic model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input int acc_cyc);
    exp_t e;
    logic [W:0] s;
    logic [W-1:0] r;
    logic co;
    if (o[2] && !LOGIC_EN) begin
      e = '{m_res, m_c, m_z, 1'b1, acc_cyc};
    end else begin
      case (o)
        3'd0: s = {1'b0, x} + {1'b0, y};
        3'd1: s = {1'b0, x} + {1'b0, y} + (W+1)'(c);
        3'd2, 3'd3: s = {x >= y, x - y};
        3'd4: s = {1'b0, x & y};
        3'd5: s = {1'b0, x | y};
        3'd6: s = {1'b0, x ^ y};
        default: s = {1'b0, ~x};
      endcase
      r = s[W-1:0];
      co = s[W];
      if (o != 3'd3) m_res = r;
      m_c = co;
      m_z = (r == '0);
      e = '{m_res, m_c, m_z, 1'b0, acc_cyc + NB};
    end
    q.push_back(e);
  endtask
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_wait_timeout", 64'(busy), 64'd0);
    op = o; a = x; b = y; cin = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    model(o, x, y, c, cyc);
    @(negedge clk);
    chk("busy_after_accept", 64'(busy), 64'd1);
  endtask
  task automatic settle();
    int n = 0;
    while ((busy || q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (prev_done && !reset) begin
      chk("done_single_pulse", 64'(done), 64'd0);
      chk("busy_after_done", 64'(busy), 64'd0);
    end
    prev_done = done;
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: done=1 with no outstanding request at cycle %0d", cyc);
      end else begin
        e = q.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("carry", 64'(carry), 64'(e.c));
        chk("zero", 64'(zero), 64'(e.z));
        chk("err", 64'(err), 64'(e.e));
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
        chk("busy_at_done", 64'(busy), 64'd1);
      end
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_cz", 64'({carry, zero}), 64'd0);
    chk("rst_alu_ab", 64'({alu_a, alu_b}), 64'd0);
    chk("rst_alu_smc", 64'({alu_s, alu_m, alu_cin}), 64'b0000_1_1);
    issue(3'd0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0);
    settle();
    issue(3'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    settle();
    issue(3'd2, 32'h0000_0010, 32'h0000_0020, 1'b0);
    settle();
    issue(3'd3, 32'd5, 32'd5, 1'b0);
    settle();
    issue(3'd1, 32'd1, 32'd1, 1'b1);
    chk("adc_first_cin", 64'({alu_s, alu_m, alu_cin}), 64'b1001_0_0);
    @(negedge clk);
    start = 1'b1; op = 3'd0;
    @(posedge clk);
    #1 start = 1'b0;
    settle();
    issue(3'd0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    m_res = '0; m_c = 1'b0; m_z = 1'b0;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_result", 64'(result), 64'd0);
    chk("abort_alu_cin", 64'(alu_cin), 64'd1);
    repeat (NB + 2) @(negedge clk);
    issue(3'd6, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0);
    settle();
    issue(3'd0, 32'd7, 32'd8, 1'b0);
    settle();
    chk("err_cleared", 64'(err), 64'd0);
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] x, y;
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? x : $urandom;
      if ($urandom_range(0, 5) == 0) x = '0;
      issue(3'($urandom_range(0, 7)), x, y, 1'($urandom_range(0, 1)));
      settle();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
